vga_sprite_engine: RTL



---
 rtl/vga_sprite_engine.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_sprite_engine.sv
// Avalon-MM 640x480 VGA sprite engine: solid square sprites over a background colour,
// frame-latched registers and a sticky collision IRQ. Define VGA_SPRITE_BOUNCE_EN for per-frame motion.
module vga_sprite_engine #(
   parameter int NUM_SPRITES = 4,
   parameter int ADDR_W      = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              chipselect,
   input  logic              write,
   input  logic              read,
   input  logic [ADDR_W-1:0] address,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              irq,
   output logic [7:0]        VGA_R,
   output logic [7:0]        VGA_G,
   output logic [7:0]        VGA_B,
   output logic              VGA_CLK,
   output logic              VGA_HS,
   output logic              VGA_VS,
   output logic              VGA_BLANK_n,
   output logic              VGA_SYNC_n
);
   localparam int BG_ADDR = 4*NUM_SPRITES;
   localparam int ST_ADDR = 4*NUM_SPRITES + 1;

   logic [10:0] hcount_q;
   logic [9:0]  vcount_q;
   logic [9:0]  pend_x_q     [NUM_SPRITES];
   logic [8:0]  pend_y_q     [NUM_SPRITES];
   logic [5:0]  pend_size_q  [NUM_SPRITES];
   logic [23:0] pend_color_q [NUM_SPRITES];
   logic [9:0]  disp_x_q     [NUM_SPRITES];
   logic [8:0]  disp_y_q     [NUM_SPRITES];
   logic [5:0]  disp_size_q  [NUM_SPRITES];
   logic [23:0] disp_color_q [NUM_SPRITES];
   logic [23:0] pend_bg_q, disp_bg_q, rgb_q, pixel_s;
   logic [15:0] frame_cnt_q;
   logic        irq_en_q, collided_q, irq_q, hs_q, vs_q, blank_n_q;
   logic [31:0] readdata_q, rdata_s;
   logic        wr_s, rd_s, latch_s, active_s, multi_s, unused_wdata_s;
   logic [NUM_SPRITES-1:0] hit_s;

   assign wr_s     = chipselect & write;
   assign rd_s     = chipselect & read;
   assign latch_s  = (hcount_q == 11'd0) && (vcount_q == 10'd480);
   assign active_s = (hcount_q < 11'd1280) && (vcount_q < 10'd480);
   assign unused_wdata_s = ^writedata[31:24];

   // Pixel/line counters: two clocks per pixel, 800x525 pixel frame
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hcount_q <= 11'd0;
         vcount_q <= 10'd0;
      end else if (hcount_q == 11'd1599) begin
         hcount_q <= 11'd0;
         vcount_q <= (vcount_q == 10'd524) ? 10'd0 : vcount_q + 10'd1;
      end else begin
         hcount_q <= hcount_q + 11'd1;
      end
   end

`ifdef VGA_SPRITE_BOUNCE_EN
   logic [7:0]  pend_dx_q [NUM_SPRITES];
   logic [7:0]  pend_dy_q [NUM_SPRITES];
   logic [9:0]  next_x_s  [NUM_SPRITES];
   logic [8:0]  next_y_s  [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] dirty_q, flip_x_s, flip_y_s;
   logic [11:0] sx_s, sy_s;

   // Signed 12-bit step with clamp-and-reflect at the screen edges
   always_comb begin
      sx_s = 12'd0;
      sy_s = 12'd0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         sx_s = {2'b00, disp_x_q[i]} + {{4{pend_dx_q[i][7]}}, pend_dx_q[i]};
         sy_s = {3'b000, disp_y_q[i]} + {{4{pend_dy_q[i][7]}}, pend_dy_q[i]};
         if (sx_s[11]) begin
            next_x_s[i] = 10'd0;
            flip_x_s[i] = 1'b1;
         end else if (sx_s + {6'd0, pend_size_q[i]} > 12'd640) begin
            next_x_s[i] = 10'(12'd640 - {6'd0, pend_size_q[i]});
            flip_x_s[i] = 1'b1;
         end else begin
            next_x_s[i] = sx_s[9:0];
            flip_x_s[i] = 1'b0;
         end
         if (sy_s[11]) begin
            next_y_s[i] = 9'd0;
            flip_y_s[i] = 1'b1;
         end else if (sy_s + {6'd0, pend_size_q[i]} > 12'd480) begin
            next_y_s[i] = 9'(12'd480 - {6'd0, pend_size_q[i]});
            flip_y_s[i] = 1'b1;
         end else begin
            next_y_s[i] = sy_s[8:0];
            flip_y_s[i] = 1'b0;
         end
      end
   end

   // Velocity and dirty flags; a CPU write in the latch cycle beats the reflection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            pend_dx_q[i] <= 8'd0;
            pend_dy_q[i] <= 8'd0;
            dirty_q[i]   <= 1'b0;
         end
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (wr_s && address == ADDR_W'(4*i + 2)) begin
               pend_dx_q[i] <= writedata[15:8];
               pend_dy_q[i] <= writedata[23:16];
            end else if (latch_s && !dirty_q[i]) begin
               if (flip_x_s[i]) pend_dx_q[i] <= 8'd0 - pend_dx_q[i];
               if (flip_y_s[i]) pend_dy_q[i] <= 8'd0 - pend_dy_q[i];
            end
            if (wr_s && (address == ADDR_W'(4*i) || address == ADDR_W'(4*i + 1))) dirty_q[i] <= 1'b1;
            else if (latch_s) dirty_q[i] <= 1'b0;
         end
      end
   end
`endif

   // Pending and display register banks; display copies pending once per frame
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            pend_x_q[i]     <= (i == 0) ? 10'd100 : 10'd0;
            pend_y_q[i]     <= (i == 0) ? 9'd100 : 9'd0;
            pend_size_q[i]  <= (i == 0) ? 6'd16 : 6'd0;
            pend_color_q[i] <= (i == 0) ? 24'hFFFFFF : 24'd0;
            disp_x_q[i]     <= (i == 0) ? 10'd100 : 10'd0;
            disp_y_q[i]     <= (i == 0) ? 9'd100 : 9'd0;
            disp_size_q[i]  <= (i == 0) ? 6'd16 : 6'd0;
            disp_color_q[i] <= (i == 0) ? 24'hFFFFFF : 24'd0;
         end
         pend_bg_q <= 24'd0;
         disp_bg_q <= 24'd0;
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (latch_s) begin
               disp_size_q[i]  <= pend_size_q[i];
               disp_color_q[i] <= pend_color_q[i];
`ifdef VGA_SPRITE_BOUNCE_EN
               disp_x_q[i]     <= dirty_q[i] ? pend_x_q[i] : next_x_s[i];
               disp_y_q[i]     <= dirty_q[i] ? pend_y_q[i] : next_y_s[i];
`else
               disp_x_q[i]     <= pend_x_q[i];
               disp_y_q[i]     <= pend_y_q[i];
`endif
            end
            if (wr_s && address == ADDR_W'(4*i))     pend_x_q[i]     <= writedata[9:0];
            if (wr_s && address == ADDR_W'(4*i + 1)) pend_y_q[i]     <= writedata[8:0];
            if (wr_s && address == ADDR_W'(4*i + 2)) pend_size_q[i]  <= writedata[5:0];
            if (wr_s && address == ADDR_W'(4*i + 3)) pend_color_q[i] <= writedata[23:0];
         end
         if (latch_s) disp_bg_q <= pend_bg_q;
         if (wr_s && address == ADDR_W'(BG_ADDR)) pend_bg_q <= writedata[23:0];
      end
   end

   // Hit test per sprite; descending scan so the lowest index wins
   always_comb begin
      hit_s   = {NUM_SPRITES{1'b0}};
      pixel_s = disp_bg_q;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         hit_s[i] = (disp_size_q[i] != 6'd0)
                 && ({1'b0, hcount_q[10:1]} >= {1'b0, disp_x_q[i]})
                 && ({1'b0, hcount_q[10:1]} <  {1'b0, disp_x_q[i]} + {5'd0, disp_size_q[i]})
                 && ({1'b0, vcount_q} >= {2'b00, disp_y_q[i]})
                 && ({1'b0, vcount_q} <  {2'b00, disp_y_q[i]} + {5'd0, disp_size_q[i]});
         pixel_s = hit_s[i] ? disp_color_q[i] : pixel_s;
      end
   end

   assign multi_s = |(hit_s & (hit_s - NUM_SPRITES'(1)));

   // Register read mux
   always_comb begin
      rdata_s = 32'd0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         if (address[ADDR_W-1:2] == (ADDR_W-2)'(i)) begin
            case (address[1:0])
`ifdef VGA_SPRITE_BOUNCE_EN
               2'd0:    rdata_s = {22'd0, disp_x_q[i]};
               2'd1:    rdata_s = {23'd0, disp_y_q[i]};
               2'd2:    rdata_s = {8'd0, pend_dy_q[i], pend_dx_q[i], 2'b00, pend_size_q[i]};
`else
               2'd0:    rdata_s = {22'd0, pend_x_q[i]};
               2'd1:    rdata_s = {23'd0, pend_y_q[i]};
               2'd2:    rdata_s = {26'd0, pend_size_q[i]};
`endif
               2'd3:    rdata_s = {8'd0, pend_color_q[i]};
               default: rdata_s = 32'd0;
            endcase
         end else begin
            rdata_s = rdata_s;
         end
      end
      if (address == ADDR_W'(BG_ADDR)) rdata_s = {8'd0, pend_bg_q};
      else if (address == ADDR_W'(ST_ADDR)) rdata_s = {frame_cnt_q, 14'd0, irq_en_q, collided_q};
      else rdata_s = rdata_s;
   end

   // Status, collision (set beats clear) and interrupt
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt_q <= 16'd0;
         irq_en_q    <= 1'b0;
         collided_q  <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         if (latch_s) frame_cnt_q <= frame_cnt_q + 16'd1;
         if (wr_s && address == ADDR_W'(ST_ADDR)) irq_en_q <= writedata[1];
         if (active_s && !hcount_q[0] && multi_s) collided_q <= 1'b1;
         else if (wr_s && address == ADDR_W'(ST_ADDR) && writedata[0]) collided_q <= 1'b0;
         irq_q <= collided_q & irq_en_q;
      end
   end

   // Registered video outputs and read data; syncs share the RGB delay
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rgb_q      <= 24'd0;
         hs_q       <= 1'b1;
         vs_q       <= 1'b1;
         blank_n_q  <= 1'b0;
         readdata_q <= 32'd0;
      end else begin
         rgb_q     <= active_s ? pixel_s : 24'd0;
         hs_q      <= !((hcount_q >= 11'd1312) && (hcount_q < 11'd1504));
         vs_q      <= !((vcount_q == 10'd490) || (vcount_q == 10'd491));
         blank_n_q <= active_s;
         if (rd_s) readdata_q <= rdata_s;
      end
   end

   assign readdata    = readdata_q;
   assign irq         = irq_q;
   assign VGA_R       = rgb_q[23:16];
   assign VGA_G       = rgb_q[15:8];
   assign VGA_B       = rgb_q[7:0];
   assign VGA_CLK     = hcount_q[0];
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_BLANK_n = blank_n_q;
   assign VGA_SYNC_n  = 1'b0;
endmodule
